// File: rtl/matrix_stream_loader.sv
// Deserialises a 16-bit element stream into two packed 8x8 matrices (A then B) plus a mode bit.
// Optional framing check on in_last is enabled by defining MATRIX_LOADER_FRAME_CHECK_EN.
module matrix_stream_loader #(
  parameter int DATA_WIDTH  = 1024,
  parameter int MATRIX_SIZE = 8,
  parameter int ELEM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] A_out,
  output logic [DATA_WIDTH-1:0] B_out,
  output logic                  Mode_out,
  output logic                  err
);

  localparam int NumElems = MATRIX_SIZE * MATRIX_SIZE;
  localparam int CntW     = $clog2(NumElems);
  localparam int IdxW     = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumElems - 1);

  typedef enum logic [1:0] {StLoadA, StLoadB, StHold} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       elem_cnt_q, elem_cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  mode_q, mode_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  beat;
  logic                  last_slot;
  logic [IdxW-1:0]       slot_msb;

  assign beat      = in_valid && in_ready_q;
  assign last_slot = (elem_cnt_q == LastCnt);
  // Element 0 lives in the MSBs, so the slot index counts down from the top.
  assign slot_msb  = IdxW'(DATA_WIDTH - 1 - ELEM_WIDTH * int'(elem_cnt_q));

  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      StLoadA: begin
        if (beat) begin
          a_d[slot_msb -: ELEM_WIDTH] = in_data;
          if (elem_cnt_q == '0) mode_d = in_mode;
          elem_cnt_d = elem_cnt_q + 1'b1;
          if (last_slot) state_d = StLoadB;
        end
      end
      StLoadB: begin
        if (beat) begin
          b_d[slot_msb -: ELEM_WIDTH] = in_data;
          elem_cnt_d = elem_cnt_q + 1'b1;
          if (last_slot) begin
            state_d     = StHold;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end
        end
      end
      StHold: begin
        if (out_valid_q && out_ready) begin
          state_d     = StLoadA;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StLoadA;
        elem_cnt_d  = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoadA;
      elem_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
  logic err_q, err_d;
  logic final_b;

  assign final_b = (state_q == StLoadB) && last_slot;

  // Sticky: flags in_last on any beat other than the final B beat, or missing on that beat.
  always_comb begin
    err_d = err_q;
    if (beat && (in_last != final_b)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign err            = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign A_out     = a_q;
  assign B_out     = b_q;
  assign Mode_out  = mode_q;

endmodule
